// File: rtl/vga_timing_if.sv
// vga_timing_if -- bundle of the run-enable input and all timing outputs of
// vga_timing_gen.
//   master : timing generator side (receives En, drives timing signals)
//   slave  : consumer side (drives En, receives timing signals)
// Signals: En (run enable), pix_tick (pixel strobe), pixel_x / pixel_y (raw
// counts, CNT_W bits), HSync, VSync, video_on, line_end, frame_start.
interface vga_timing_if #(
  parameter int CNT_W = 10
) ();
  logic             En;
  logic             pix_tick;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             HSync;
  logic             VSync;
  logic             video_on;
  logic             line_end;
  logic             frame_start;

  modport master (
    input  En,
    output pix_tick, pixel_x, pixel_y, HSync, VSync, video_on, line_end, frame_start
  );

  modport slave (
    output En,
    input  pix_tick, pixel_x, pixel_y, HSync, VSync, video_on, line_end, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- programmable VGA raster timing generator.
// A prescaler divides Clk down to the pixel rate; pixel_x / pixel_y count the
// raster and HSync / VSync / video_on are registered decodes of the counters
// as they stand after each edge, so they carry no skew against the counts.
// Ports:
//   Clk   : system clock
//   Reset : asynchronous active-low reset
//   bus   : vga_timing_if.master (En in; pix_tick, pixel_x, pixel_y, HSync,
//           VSync, video_on, line_end, frame_start out)
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  vga_timing_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             von_q, von_d;
  logic             le_q, le_d;
  logic             fs_q, fs_d;
  logic             tick_s;
  logic             x_wrap_s;
  logic             y_wrap_s;

  // Next-state for prescaler and raster counters, plus decode of the new counts
  always_comb begin
    // Reset gates the strobe so it is low during reset even with CLK_DIV=1.
    tick_s   = Reset & bus.En & (pre_q == PRE_LAST);
    x_wrap_s = (x_q == X_LAST);
    y_wrap_s = (y_q == Y_LAST);

    pre_d = pre_q;
    x_d   = x_q;
    y_d   = y_q;

    if (bus.En) begin
      if (pre_q == PRE_LAST) begin
        pre_d = {PRE_W{1'b0}};
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end else begin
      pre_d = pre_q;
    end

    if (tick_s) begin
      if (x_wrap_s) begin
        x_d = {CNT_W{1'b0}};
        if (y_wrap_s) begin
          y_d = {CNT_W{1'b0}};
        end else begin
          y_d = y_q + CNT_W'(1);
        end
      end else begin
        x_d = x_q + CNT_W'(1);
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end

    // Decode from the post-edge counts so the registered flags line up with them.
    hs_d  = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HS_POL : ~HS_POL;
    vs_d  = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VS_POL : ~VS_POL;
    von_d = (x_d < X_ACT) && (y_d < Y_ACT);
    le_d  = tick_s & x_wrap_s;
    fs_d  = tick_s & x_wrap_s & y_wrap_s;
  end

  // State and output registers; reset parks everything at the idle values
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pre_q <= {PRE_W{1'b0}};
      x_q   <= {CNT_W{1'b0}};
      y_q   <= {CNT_W{1'b0}};
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      von_q <= 1'b0;
      le_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      von_q <= von_d;
      le_q  <= le_d;
      fs_q  <= fs_d;
    end
  end

  assign bus.pix_tick    = tick_s;
  assign bus.pixel_x     = x_q;
  assign bus.pixel_y     = y_q;
  assign bus.HSync       = hs_q;
  assign bus.VSync       = vs_q;
  assign bus.video_on    = von_q;
  assign bus.line_end    = le_q;
  assign bus.frame_start = fs_q;

endmodule
